// File: rtl/rv_wb_pkg.sv
// Shared types for the writeback arbiter: register index, load-buffer entry and
// the default load-buffer depth.
package rv_wb_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t    rd;
        logic [31:0] data;
    } wb_entry_t;

    localparam int unsigned WB_ENTRY_W   = $bits(wb_entry_t);
    localparam int unsigned LD_DEPTH_DFLT = 2;

endpackage

// File: rtl/rv_wb_fifo.sv
// Synchronous FIFO of writeback entries with count-based full/empty flags.
// Depth must be a power of two so the pointers wrap naturally.
module rv_wb_fifo
    import rv_wb_pkg::*;
#(
    parameter int unsigned Depth = LD_DEPTH_DFLT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [WB_ENTRY_W-1:0] wdata_i,
    input  logic                  pop_i,
    output logic [WB_ENTRY_W-1:0] rdata_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    wb_entry_t       mem_q [Depth];
    wb_entry_t       mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wb_entry_t'(wdata_i);
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rv_wb_arb.sv
// Writeback arbiter: merges ALU and buffered load results onto the register-file
// write port and keeps a pending-load scoreboard that drives the issue stall.
module rv_wb_arb
    import rv_wb_pkg::*;
#(
    parameter int unsigned LD_DEPTH = LD_DEPTH_DFLT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    input  logic        i_ld_valid,
    output logic        o_ld_ready,
    input  logic [4:0]  i_ld_rd,
    input  logic [31:0] i_ld_data,
    input  logic        i_ld_issue,
    input  logic [4:0]  i_ld_issue_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    output logic        o_stall,
    output logic        o_write,
    output logic [4:0]  o_rd,
    output logic [31:0] o_data
);

    wb_entry_t   ld_in;
    wb_entry_t   ld_head;
    logic        ld_full;
    logic        ld_empty;
    logic        ld_push;
    logic        ld_pop;

    logic        write_q, write_d;
    reg_idx_t    rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pending_q, pending_d;
    logic        bypass_hit;

    assign ld_in      = '{rd: i_ld_rd, data: i_ld_data};
    assign o_ld_ready = ~ld_full;
    assign ld_push    = i_ld_valid & o_ld_ready;
    assign ld_pop     = ~i_alu_valid & ~ld_empty;

    rv_wb_fifo #(
        .Depth (LD_DEPTH)
    ) u_ld_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .push_i  (ld_push),
        .wdata_i (ld_in),
        .pop_i   (ld_pop),
        .rdata_o (ld_head),
        .full_o  (ld_full),
        .empty_o (ld_empty)
    );

    // The register file reads the old value on the edge that writes the new one.
    assign bypass_hit = write_q & (rd_q != '0) & ((rd_q == i_rs1) | (rd_q == i_rs2));
    assign o_stall    = pending_q[i_rs1] | pending_q[i_rs2] | bypass_hit
                      | (i_ld_issue & pending_q[i_ld_issue_rd]);

    always_comb begin
        write_d = 1'b0;
        rd_d    = rd_q;
        data_d  = data_q;
        if (i_alu_valid) begin
            write_d = (i_alu_rd != '0);
            rd_d    = i_alu_rd;
            data_d  = i_alu_data;
        end else if (ld_pop) begin
            write_d = (ld_head.rd != '0);
            rd_d    = ld_head.rd;
            data_d  = ld_head.data;
        end
    end

    // Clear is applied after set so it wins if both ever hit the same bit.
    always_comb begin
        pending_d = pending_q;
        if (i_ld_issue & ~o_stall) begin
            pending_d[i_ld_issue_rd] = 1'b1;
        end
        if (ld_pop) begin
            pending_d[ld_head.rd] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            write_q   <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            pending_q <= '0;
        end else begin
            write_q   <= write_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end

    assign o_write = write_q;
    assign o_rd    = rd_q;
    assign o_data  = data_q;

endmodule

// File: tb/tb_rv_wb_arb.sv
// Directed self-checking bench for rv_wb_arb with hand-computed expectations.
module tb_rv_wb_arb;

    logic        i_clk;
    logic        i_reset;
    logic        i_alu_valid;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        i_ld_valid;
    logic        o_ld_ready;
    logic [4:0]  i_ld_rd;
    logic [31:0] i_ld_data;
    logic        i_ld_issue;
    logic [4:0]  i_ld_issue_rd;
    logic [4:0]  i_rs1;
    logic [4:0]  i_rs2;
    logic        o_stall;
    logic        o_write;
    logic [4:0]  o_rd;
    logic [31:0] o_data;

    int n_tests = 0;
    int n_fail  = 0;

    rv_wb_arb #(
        .LD_DEPTH (2)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_alu_valid   (i_alu_valid),
        .i_alu_rd      (i_alu_rd),
        .i_alu_data    (i_alu_data),
        .i_ld_valid    (i_ld_valid),
        .o_ld_ready    (o_ld_ready),
        .i_ld_rd       (i_ld_rd),
        .i_ld_data     (i_ld_data),
        .i_ld_issue    (i_ld_issue),
        .i_ld_issue_rd (i_ld_issue_rd),
        .i_rs1         (i_rs1),
        .i_rs2         (i_rs2),
        .o_stall       (o_stall),
        .o_write       (o_write),
        .o_rd          (o_rd),
        .o_data        (o_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; inputs set afterwards apply to the next edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_alu_valid   = 1'b0;
        i_alu_rd      = '0;
        i_alu_data    = '0;
        i_ld_valid    = 1'b0;
        i_ld_rd       = '0;
        i_ld_data     = '0;
        i_ld_issue    = 1'b0;
        i_ld_issue_rd = '0;
        i_rs1         = '0;
        i_rs2         = '0;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        i_alu_valid = v;
        i_alu_rd    = rd;
        i_alu_data  = d;
    endtask

    task automatic ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
        i_ld_valid = v;
        i_ld_rd    = rd;
        i_ld_data  = d;
    endtask

    initial begin
        idle_inputs();
        i_reset = 1'b1;
        #12;
        check("rst_write", {31'd0, o_write}, 32'd0);
        check("rst_rd", {27'd0, o_rd}, 32'd0);
        check("rst_data", o_data, 32'd0);
        i_reset = 1'b0;
        step();
        check("rst_ready", {31'd0, o_ld_ready}, 32'd1);
        check("rst_stall", {31'd0, o_stall}, 32'd0);

        // ALU only
        alu(1'b1, 5'd5, 32'h1234);
        step();
        check("alu_write", {31'd0, o_write}, 32'd1);
        check("alu_rd", {27'd0, o_rd}, 32'd5);
        check("alu_data", o_data, 32'h1234);
        alu(1'b1, 5'd0, 32'h77);
        step();
        check("alu_x0_write", {31'd0, o_write}, 32'd0);

        // Bypass hazard on the write port
        alu(1'b1, 5'd3, 32'h33);
        step();
        alu(1'b0, 5'd0, 32'h0);
        i_rs2 = 5'd3;
        #1;
        check("bypass_rs2", {31'd0, o_stall}, 32'd1);
        i_rs2 = 5'd0;
        i_rs1 = 5'd3;
        #1;
        check("bypass_rs1", {31'd0, o_stall}, 32'd1);
        i_rs1 = 5'd0;
        alu(1'b1, 5'd0, 32'h44);
        step();
        alu(1'b0, 5'd0, 32'h0);
        #1;
        check("bypass_x0", {31'd0, o_stall}, 32'd0);
        step();

        // Contention: ALU busy for 3 cycles while loads arrive
        alu(1'b1, 5'd1, 32'h1);
        ld(1'b1, 5'd7, 32'hAA);
        step();
        check("cont_c0_rd", {27'd0, o_rd}, 32'd1);
        check("cont_c0_ready", {31'd0, o_ld_ready}, 32'd1);
        alu(1'b1, 5'd2, 32'h2);
        ld(1'b1, 5'd8, 32'hBB);
        step();
        check("cont_c1_ready", {31'd0, o_ld_ready}, 32'd0);
        alu(1'b1, 5'd4, 32'h4);
        ld(1'b1, 5'd10, 32'hCC);
        step();
        check("cont_c2_rd", {27'd0, o_rd}, 32'd4);
        check("cont_c2_ready", {31'd0, o_ld_ready}, 32'd0);
        alu(1'b0, 5'd0, 32'h0);
        step();
        check("cont_ld7_write", {31'd0, o_write}, 32'd1);
        check("cont_ld7_rd", {27'd0, o_rd}, 32'd7);
        check("cont_ld7_data", o_data, 32'hAA);
        check("cont_ready_back", {31'd0, o_ld_ready}, 32'd1);
        step();
        ld(1'b0, 5'd0, 32'h0);
        check("cont_ld8_rd", {27'd0, o_rd}, 32'd8);
        check("cont_ld8_data", o_data, 32'hBB);
        step();
        check("cont_ld10_rd", {27'd0, o_rd}, 32'd10);
        check("cont_ld10_data", o_data, 32'hCC);
        step();
        check("cont_drained", {31'd0, o_write}, 32'd0);

        // Load to x0 is popped but not written
        ld(1'b1, 5'd0, 32'hDD);
        step();
        ld(1'b0, 5'd0, 32'h0);
        step();
        check("ld_x0_write", {31'd0, o_write}, 32'd0);
        check("ld_x0_ready", {31'd0, o_ld_ready}, 32'd1);

        // Scoreboard
        i_ld_issue    = 1'b1;
        i_ld_issue_rd = 5'd9;
        #1;
        check("sb_issue_ok", {31'd0, o_stall}, 32'd0);
        step();
        i_ld_issue = 1'b0;
        i_rs1      = 5'd9;
        #1;
        check("sb_rs1_pending", {31'd0, o_stall}, 32'd1);
        step();
        check("sb_rs1_hold", {31'd0, o_stall}, 32'd1);
        i_rs1      = 5'd0;
        i_ld_issue = 1'b1;
        #1;
        check("sb_waw_stall", {31'd0, o_stall}, 32'd1);
        step();
        i_ld_issue = 1'b0;
        i_rs1      = 5'd9;
        #1;
        check("sb_waw_bit_kept", {31'd0, o_stall}, 32'd1);
        ld(1'b1, 5'd9, 32'h99);
        step();
        ld(1'b0, 5'd0, 32'h0);
        #1;
        check("sb_buffered", {31'd0, o_stall}, 32'd1);
        step();
        check("sb_wr9_rd", {27'd0, o_rd}, 32'd9);
        check("sb_wr9_data", o_data, 32'h99);
        check("sb_wr9_stall", {31'd0, o_stall}, 32'd1);
        step();
        check("sb_readable", {31'd0, o_stall}, 32'd0);
        i_rs1 = 5'd0;

        // Reset mid-stream with two loads buffered and one pending
        alu(1'b1, 5'd11, 32'h11);
        ld(1'b1, 5'd12, 32'h120);
        i_ld_issue    = 1'b1;
        i_ld_issue_rd = 5'd13;
        step();
        i_ld_issue = 1'b0;
        ld(1'b1, 5'd14, 32'h140);
        step();
        check("pre_rst_full", {31'd0, o_ld_ready}, 32'd0);
        idle_inputs();
        i_rs1 = 5'd13;
        #1;
        check("pre_rst_pending", {31'd0, o_stall}, 32'd1);
        #1;
        i_reset = 1'b1;
        #1;
        check("mid_rst_write", {31'd0, o_write}, 32'd0);
        check("mid_rst_ready", {31'd0, o_ld_ready}, 32'd1);
        check("mid_rst_pending", {31'd0, o_stall}, 32'd0);
        step();
        i_reset = 1'b0;
        step();
        check("post_rst_write0", {31'd0, o_write}, 32'd0);
        step();
        check("post_rst_write1", {31'd0, o_write}, 32'd0);
        check("post_rst_ready", {31'd0, o_ld_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
